// File: rtl/vga_frame_scaler.sv
// vga_frame_scaler: converts raster position into framebuffer read addresses with integer
// pixel replication and aligns RAM read data to pixel_out. Optional feature: VGA_TEST_PATTERN_EN.
module vga_frame_scaler #(
    parameter int                 H_ACTIVE     = 640,
    parameter int                 V_ACTIVE     = 480,
    parameter int                 SCALE        = 2,
    parameter int                 ADDR_W       = 20,
    parameter int                 PIXEL_W      = 24,
    parameter int                 MEM_LATENCY  = 1,
    parameter logic [PIXEL_W-1:0] BORDER_COLOR = 24'h000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        vga_h,
    input  logic [10:0]        vga_v,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [PIXEL_W-1:0] mem_data,
    output logic [ADDR_W-1:0]  read_address,
    output logic               read_en,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid,
    output logic               frame_start
);

    localparam int               AW1       = ADDR_W + 32'sd1;
    localparam int               SRC_LINE  = H_ACTIVE / SCALE;
    localparam int               DL        = MEM_LATENCY + 32'sd1;
    localparam longint           MAX_ADDR  = longint'(H_ACTIVE / SCALE) * longint'(V_ACTIVE / SCALE) - 64'sd1;
    localparam logic [AW1-1:0]   ROW_STEP  = AW1'(SRC_LINE);
    localparam logic [AW1-1:0]   ONE_A     = AW1'(32'sd1);
    localparam logic [2:0]       SUB_MAX   = 3'(SCALE - 32'sd1);

    if ((SCALE < 32'sd1) || (SCALE > 32'sd8)) begin : g_chk_scale
        $error("vga_frame_scaler: SCALE must be in 1..8");
    end
    if (((H_ACTIVE % SCALE) != 32'sd0) || ((V_ACTIVE % SCALE) != 32'sd0)) begin : g_chk_div
        $error("vga_frame_scaler: H_ACTIVE and V_ACTIVE must be multiples of SCALE");
    end
    if ((MEM_LATENCY < 32'sd1) || (MEM_LATENCY > 32'sd4)) begin : g_chk_lat
        $error("vga_frame_scaler: MEM_LATENCY must be in 1..4");
    end
    if (MAX_ADDR >= (64'sd1 << ADDR_W)) begin : g_chk_addr
        $error("vga_frame_scaler: source image does not fit ADDR_W");
    end

    logic           w_active;
    logic           w_line_start;
    logic           w_frame_start;
    logic           w_test;
    logic [AW1-1:0] r_row_base, w_row_base;
    logic [AW1-1:0] r_src_x, w_src_x, w_src_x_nx;
    logic [AW1-1:0] w_addr;
    logic [2:0]     r_x_sub, w_x_sub, w_x_sub_nx;
    logic [2:0]     r_y_sub, w_y_sub;
    logic [10:0]    r_prev_v, w_prev_v;
    logic [DL-1:0]  r_act_dl;
    logic [DL-1:0]  r_fs_dl;
    logic [PIXEL_W-1:0] w_pixel_src;

    // 2047 on either counter is also excluded explicitly so wider active areas stay safe
    assign w_active      = (vga_h < 11'(H_ACTIVE)) && (vga_v < 11'(V_ACTIVE)) &&
                           (vga_h != 11'h7FF) && (vga_v != 11'h7FF);
    assign w_line_start  = (vga_h == 11'd0);
    assign w_frame_start = (vga_h == 11'd0) && (vga_v == 11'd0);

`ifdef VGA_TEST_PATTERN_EN
    assign w_test = test_mode;
`else
    assign w_test = 1'b0;
`endif

    // Line/frame start handling: counter values that apply to the pixel being sampled now
    always_comb begin
        w_row_base = r_row_base;
        w_y_sub    = r_y_sub;
        w_prev_v   = r_prev_v;
        w_src_x    = r_src_x;
        w_x_sub    = r_x_sub;
        if (w_frame_start) begin
            w_row_base = '0;
            w_y_sub    = 3'd0;
            w_prev_v   = 11'd0;
            w_src_x    = '0;
            w_x_sub    = 3'd0;
        end else if (w_line_start) begin
            w_src_x  = '0;
            w_x_sub  = 3'd0;
            w_prev_v = vga_v;
            if (vga_v != r_prev_v) begin
                if (r_y_sub == SUB_MAX) begin
                    w_y_sub    = 3'd0;
                    w_row_base = r_row_base + ROW_STEP;
                end else begin
                    w_y_sub = r_y_sub + 3'd1;
                end
            end else begin
                w_y_sub = r_y_sub;
            end
        end else begin
            w_prev_v = r_prev_v;
        end
    end

    // Address for this pixel and horizontal advance after it
    always_comb begin
        w_addr     = w_row_base + w_src_x;
        w_src_x_nx = w_src_x;
        w_x_sub_nx = w_x_sub;
        if (w_active) begin
            if (w_x_sub == SUB_MAX) begin
                w_x_sub_nx = 3'd0;
                w_src_x_nx = w_src_x + ONE_A;
            end else begin
                w_x_sub_nx = w_x_sub + 3'd1;
            end
        end else begin
            w_src_x_nx = w_src_x;
        end
    end

    // Counter state and registered read request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_base   <= '0;
            r_y_sub      <= 3'd0;
            r_prev_v     <= 11'd0;
            r_src_x      <= '0;
            r_x_sub      <= 3'd0;
            read_address <= '0;
            read_en      <= 1'b0;
        end else begin
            r_row_base <= w_row_base;
            r_y_sub    <= w_y_sub;
            r_prev_v   <= w_prev_v;
            r_src_x    <= w_src_x_nx;
            r_x_sub    <= w_x_sub_nx;
            read_en    <= w_active && !w_test;
            if (w_active) begin
                read_address <= w_addr[ADDR_W-1:0];
            end else begin
                read_address <= read_address;
            end
        end
    end

    // Flag delay line matching the address register plus RAM latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_dl <= '0;
            r_fs_dl  <= '0;
        end else if (DL > 32'sd1) begin
            r_act_dl <= {r_act_dl[DL-2:0], w_active};
            r_fs_dl  <= {r_fs_dl[DL-2:0], w_frame_start};
        end else begin
            r_act_dl <= DL'(w_active);
            r_fs_dl  <= DL'(w_frame_start);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 32'sd8;

    logic [10:0]   r_h_dl [DL];
    logic [DL-1:0] r_tm_dl;

    function automatic logic [PIXEL_W-1:0] bar_color(input logic [10:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 11'(i * BAR_W)) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        case (idx)
            3'd0:    bar_color = PIXEL_W'(24'hFFFFFF);
            3'd1:    bar_color = PIXEL_W'(24'hFFFF00);
            3'd2:    bar_color = PIXEL_W'(24'h00FFFF);
            3'd3:    bar_color = PIXEL_W'(24'h00FF00);
            3'd4:    bar_color = PIXEL_W'(24'hFF00FF);
            3'd5:    bar_color = PIXEL_W'(24'hFF0000);
            3'd6:    bar_color = PIXEL_W'(24'h0000FF);
            default: bar_color = PIXEL_W'(24'h000000);
        endcase
    endfunction

    // Horizontal position and test_mode travel alongside the active flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DL; i++) begin
                r_h_dl[i] <= 11'd0;
            end
            r_tm_dl <= '0;
        end else begin
            r_h_dl[0] <= vga_h;
            for (int i = 1; i < DL; i++) begin
                r_h_dl[i] <= r_h_dl[i-1];
            end
            if (DL > 32'sd1) begin
                r_tm_dl <= {r_tm_dl[DL-2:0], test_mode};
            end else begin
                r_tm_dl <= DL'(test_mode);
            end
        end
    end

    assign w_pixel_src = r_tm_dl[DL-1] ? bar_color(r_h_dl[DL-1]) : mem_data;
`else
    assign w_pixel_src = mem_data;
`endif

    // Output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out   <= BORDER_COLOR;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_valid <= r_act_dl[DL-1];
            frame_start <= r_fs_dl[DL-1];
            pixel_out   <= r_act_dl[DL-1] ? w_pixel_src : BORDER_COLOR;
        end
    end

endmodule
